// File: rtl/mbox_mem_ref_ctl.sv
// MBOX memory reference controller: round-robin arbitration of NCHAN requesters
// onto one SBUS port, NXM timeout and cleanup, sticky error flags and ERA capture.
//
// state  | meaning
// IDLE   | no reference; arbitrate START, grant and latch the winner
// REQ    | MEM_START asserted, waiting for ACKN, counting toward timeout
// RDWAIT | read acknowledged, waiting for DATA_VAL, counting toward timeout
// NXM    | five-cycle cleanup T2..T6; T6 sets NXM_ERR and fakes data-valid on reads
module mbox_mem_ref_ctl #(
  parameter int NCHAN   = 4,
  parameter int ADR_W   = 22,
  parameter int TMO_W   = 8,
  parameter int TIMEOUT = 200
) (
  input  logic                   clk,
  input  logic                   RESET_N,
  input  logic [NCHAN-1:0]       START,
  input  logic [NCHAN-1:0]       RD_RQ,
  input  logic [NCHAN-1:0]       WR_RQ,
  input  logic [NCHAN*ADR_W-1:0] ADR,
  output logic [NCHAN-1:0]       GRANT,
  output logic                   MEM_START,
  output logic [ADR_W-1:0]       MEM_ADR,
  output logic                   MEM_RD,
  input  logic                   ACKN,
  input  logic                   DATA_VAL,
  input  logic                   MEM_ERROR,
  output logic                   CORE_BUSY,
  output logic                   NXM_DATA_VAL,
  output logic [NCHAN-1:0]       NXM_ERR,
  input  logic [NCHAN-1:0]       ERR_CLR,
  output logic                   ERA_VALID,
  output logic [ADR_W+5:0]       ERA,
  input  logic [1:0]             DIAG_SEL,
  output logic [35:0]            DIAG_DATA
);

  localparam int PTR_W = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam int D0_W  = 3 + TMO_W + 2 + PTR_W;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_REQ    = 3'd1;
  localparam logic [2:0] ST_RDWAIT = 3'd2;
  localparam logic [2:0] ST_NXM    = 3'd3;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [2:0]       NXM_LAST = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic [2:0]       ph_q, ph_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] chan_q, chan_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic             rd_q, rd_d;
  logic             rpw_q, rpw_d;
  logic [NCHAN-1:0] grant_q, grant_d;
  logic             mem_start_q, mem_start_d;
  logic             core_busy_q, core_busy_d;
  logic             ndv_q, ndv_d;
  logic [NCHAN-1:0] nxm_err_q, nxm_err_d;
  logic             era_valid_q, era_valid_d;
  logic [ADR_W+5:0] era_q, era_d;

  logic             req_found;
  logic [PTR_W-1:0] req_sel;
  logic [PTR_W-1:0] req_idx;
  logic [ADR_W-1:0] sel_adr;
  logic             sel_rd;
  logic             sel_wr;
  logic             nxm_entry;
  logic             t6_done;
  logic             merr_hit;
  logic             clr_hit;
  logic             era_capture;
  logic [35:0]      diag_data;

  // Round-robin pick: first asserted START at or after the pointer.
  always_comb begin
    req_found = 1'b0;
    req_sel   = '0;
    req_idx   = '0;
    for (int j = 0; j < NCHAN; j++) begin
      req_idx = PTR_W'((int'(ptr_q) + j) % NCHAN);
      if (!req_found && START[req_idx]) begin
        req_found = 1'b1;
        req_sel   = req_idx;
      end
    end
    sel_adr = '0;
    sel_rd  = 1'b0;
    sel_wr  = 1'b0;
    for (int i = 0; i < NCHAN; i++) begin
      if (req_sel == PTR_W'(i)) begin
        sel_adr = ADR[i*ADR_W +: ADR_W];
        sel_rd  = RD_RQ[i];
        sel_wr  = WR_RQ[i];
      end
    end
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ph_q    <= '0;
      ptr_q   <= '0;
      chan_q  <= '0;
      adr_q   <= '0;
      rd_q    <= 1'b0;
      rpw_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
      ptr_q   <= ptr_d;
      chan_q  <= chan_d;
      adr_q   <= adr_d;
      rd_q    <= rd_d;
      rpw_q   <= rpw_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ph_d      = ph_q;
    ptr_d     = ptr_q;
    chan_d    = chan_q;
    adr_d     = adr_q;
    rd_d      = rd_q;
    rpw_d     = rpw_q;
    grant_d   = '0;
    nxm_entry = 1'b0;
    t6_done   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (req_found) begin
          state_d = ST_REQ;
          grant_d = NCHAN'(1) << req_sel;
          chan_d  = req_sel;
          adr_d   = sel_adr;
          rd_d    = sel_rd;
          rpw_d   = sel_rd & sel_wr;
          ptr_d   = (req_sel == PTR_W'(NCHAN - 1)) ? '0 : req_sel + 1'b1;
        end
      end
      ST_REQ: begin
        // ACKN is tested first so it wins over a same-cycle timeout.
        if (ACKN) begin
          state_d = rd_q ? ST_RDWAIT : ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == TMO_LAST) begin
          state_d   = ST_NXM;
          ph_d      = '0;
          nxm_entry = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RDWAIT: begin
        if (DATA_VAL) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == TMO_LAST) begin
          state_d   = ST_NXM;
          ph_d      = '0;
          nxm_entry = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_NXM: begin
        if (ph_q == NXM_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          t6_done = 1'b1;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    mem_start_d = (state_d == ST_REQ);
    core_busy_d = (state_d != ST_IDLE);
    ndv_d       = t6_done & rd_q;
    merr_hit    = (state_q == ST_REQ) & ACKN & MEM_ERROR;

    // A flag being set at T6 outranks a same-cycle clear.
    nxm_err_d = (nxm_err_q & ~ERR_CLR) | (t6_done ? (NCHAN'(1) << chan_q) : '0);

    clr_hit = 1'b0;
    for (int i = 0; i < NCHAN; i++) begin
      if (ERR_CLR[i] && (era_q[ADR_W+5 -: 3] == 3'(i))) clr_hit = 1'b1;
    end

    era_capture = (nxm_entry | merr_hit) & (~era_valid_q | clr_hit);
    era_d       = era_capture ? {3'(chan_q), rpw_q, rd_q, nxm_entry, adr_q} : era_q;
    era_valid_d = era_capture ? 1'b1 : (clr_hit ? 1'b0 : era_valid_q);

    diag_data = '0;
    case (DIAG_SEL)
      2'd0:    diag_data[D0_W-1:0]    = {state_q, cnt_q, core_busy_q, rd_q, ptr_q};
      2'd1:    diag_data[NCHAN-1:0]   = nxm_err_q;
      2'd2:    diag_data[ADR_W+5:0]   = era_q;
      default: diag_data[ADR_W-1:0]   = adr_q;
    endcase
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      grant_q     <= '0;
      mem_start_q <= 1'b0;
      core_busy_q <= 1'b0;
      ndv_q       <= 1'b0;
      nxm_err_q   <= '0;
      era_valid_q <= 1'b0;
      era_q       <= '0;
    end else begin
      grant_q     <= grant_d;
      mem_start_q <= mem_start_d;
      core_busy_q <= core_busy_d;
      ndv_q       <= ndv_d;
      nxm_err_q   <= nxm_err_d;
      era_valid_q <= era_valid_d;
      era_q       <= era_d;
    end
  end

  assign GRANT        = grant_q;
  assign MEM_START    = mem_start_q;
  assign MEM_ADR      = adr_q;
  assign MEM_RD       = rd_q;
  assign CORE_BUSY    = core_busy_q;
  assign NXM_DATA_VAL = ndv_q;
  assign NXM_ERR      = nxm_err_q;
  assign ERA_VALID    = era_valid_q;
  assign ERA          = era_q;
  assign DIAG_DATA    = diag_data;

endmodule
